// File: rtl/btn_event_unit.sv
// Per-channel button front end: synchronize, debounce, then press/release/long/repeat pulses.
// Auto-repeat pulses exist only when BTN_AUTOREPEAT_EN is defined; otherwise repeat_pulse is 0.
module btn_event_unit #(
  parameter int unsigned N_BTN           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 800000,
  parameter int unsigned LONG_CYCLES     = 50000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse,
  output logic [N_BTN-1:0] repeat_pulse
);

  localparam int unsigned DbW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HoldMax = (LONG_CYCLES > REPEAT_DELAY) ? LONG_CYCLES : REPEAT_DELAY;
  localparam int unsigned HoldW   = $clog2(HoldMax + 1);

  localparam logic [DbW-1:0]   DbLast  = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldSat = HoldW'(HoldMax);
  localparam logic [HoldW-1:0] LongM1  = HoldW'(LONG_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RepW   = $clog2(RepMax + 1);
  localparam logic [RepW-1:0] RepDelayM1  = RepW'(REPEAT_DELAY - 1);
  localparam logic [RepW-1:0] RepPeriodM1 = RepW'(REPEAT_PERIOD - 1);
`endif

  typedef enum logic [1:0] {StIdle, StPressed, StLong} state_e;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    logic             r_sync1, r_sync2, r_level;
    logic             r_press, r_release, r_long;
    logic [DbW-1:0]   r_db_cnt;
    logic [HoldW-1:0] r_hold;
    state_e           r_state;
    logic             w_toggle, w_rise, w_fall;

    // Level flips on the DEBOUNCE_CYCLES-th consecutive mismatching edge.
    assign w_toggle = (r_sync2 != r_level) && (r_db_cnt == DbLast);
    assign w_rise   = w_toggle && !r_level;
    assign w_fall   = w_toggle && r_level;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_sync1   <= 1'b0;
        r_sync2   <= 1'b0;
        r_level   <= 1'b0;
        r_db_cnt  <= '0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
        r_hold    <= '0;
        r_state   <= StIdle;
      end else begin
        r_sync1 <= btn[i];
        r_sync2 <= r_sync1;
        if (r_sync2 == r_level) begin
          r_db_cnt <= '0;
        end else if (w_toggle) begin
          r_db_cnt <= '0;
          r_level  <= ~r_level;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
        r_press   <= w_rise;
        r_release <= w_fall;
        r_long    <= 1'b0;
        unique case (r_state)
          StIdle: begin
            r_hold <= '0;
            if (w_rise) r_state <= StPressed;
          end
          StPressed, StLong: begin
            if (w_fall) begin
              r_state <= StIdle;
              r_hold  <= '0;
            end else begin
              if (r_state == StPressed && r_hold == LongM1) begin
                r_state <= StLong;
                r_long  <= 1'b1;
              end
              if (r_hold != HoldSat) r_hold <= r_hold + 1'b1;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end

    assign btn_level[i]     = r_level;
    assign press_pulse[i]   = r_press;
    assign release_pulse[i] = r_release;
    assign long_pulse[i]    = r_long;

`ifdef BTN_AUTOREPEAT_EN
    logic [RepW-1:0] r_rep_cnt;
    logic            r_rep;

    // Counts down to the next repeat; reloaded with the delay on each press.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_rep_cnt <= '0;
        r_rep     <= 1'b0;
      end else begin
        r_rep <= 1'b0;
        if (w_rise) begin
          r_rep_cnt <= RepDelayM1;
        end else if (r_level && !w_fall) begin
          if (r_rep_cnt == '0) begin
            r_rep     <= 1'b1;
            r_rep_cnt <= RepPeriodM1;
          end else begin
            r_rep_cnt <= r_rep_cnt - 1'b1;
          end
        end
      end
    end

    assign repeat_pulse[i] = r_rep;
`endif
  end

`ifndef BTN_AUTOREPEAT_EN
  assign repeat_pulse = '0;
`endif

endmodule

// File: tb/tb_btn_event_unit.sv
// Directed bench for btn_event_unit (N_BTN=5, debounce 4, long 20, repeat 10/4).
// Repeat expectations follow whether BTN_AUTOREPEAT_EN is defined for the build.
module tb_btn_event_unit;

  localparam int unsigned NB      = 5;
  localparam int          LastCyc = 92;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn;
  logic [NB-1:0] btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse;

  int cyc;
  int n_checks = 0;
  int n_pass   = 0;

  btn_event_unit #(
    .N_BTN          (NB),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (4)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .btn          (btn),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%b expected=%b", tag, cyc, got, exp);
  endtask

  function automatic logic in_rng(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  // Raw button value sampled at edge c.
  function automatic logic [NB-1:0] drv_btn(input int c);
    logic [NB-1:0] b;
    if (c >= 60) return '1;
    b[0] = in_rng(c, 10, 49);
    b[1] = in_rng(c, 10, 12);
    b[2] = in_rng(c, 10, 39);
    b[3] = in_rng(c, 10, 28);
    b[4] = in_rng(c, 20, 23);
    return b;
  endfunction

  function automatic logic [NB-1:0] exp_level(input int c);
    logic          p2;
    logic [NB-1:0] e;
    p2   = in_rng(c, 65, 69) || (c >= 76);
    e[0] = in_rng(c, 15, 54) || p2;
    e[1] = p2;
    e[2] = in_rng(c, 15, 44) || p2;
    e[3] = in_rng(c, 15, 33) || p2;
    e[4] = in_rng(c, 25, 28) || p2;
    return e;
  endfunction

  function automatic logic [NB-1:0] exp_press(input int c);
    logic          p2;
    logic [NB-1:0] e;
    p2   = (c == 65) || (c == 76);
    e[0] = (c == 15) || p2;
    e[1] = p2;
    e[2] = (c == 15) || p2;
    e[3] = (c == 15) || p2;
    e[4] = (c == 25) || p2;
    return e;
  endfunction

  function automatic logic [NB-1:0] exp_release(input int c);
    logic [NB-1:0] e;
    e[0] = (c == 55);
    e[1] = 1'b0;
    e[2] = (c == 45);
    e[3] = (c == 34);
    e[4] = (c == 29);
    return e;
  endfunction

  function automatic logic [NB-1:0] exp_long(input int c);
    logic [NB-1:0] e;
    e    = '0;
    e[0] = (c == 35);
    e[2] = (c == 35);
    return e;
  endfunction

  function automatic logic [NB-1:0] exp_repeat(input int c);
    logic [NB-1:0] e;
    e = '0;
`ifdef BTN_AUTOREPEAT_EN
    if (c == 86 || c == 90) return '1;
    e[0] = in_rng(c, 25, 53) && ((c - 25) % 4 == 0);
    e[2] = in_rng(c, 25, 41) && ((c - 25) % 4 == 0);
    e[3] = (c == 25) || (c == 29) || (c == 33);
`endif
    return e;
  endfunction

  initial begin
    cyc = 0;
    rst = 1'b1;
    btn = '0;
    for (int c = 1; c <= LastCyc; c++) begin
      // Inputs for edge c are set half a period before it.
      rst = (c <= 2) || (c == 70);
      btn = drv_btn(c);
      @(posedge clk);
      @(negedge clk);
      cyc = c;
      check("btn_level", btn_level, exp_level(c));
      check("press_pulse", press_pulse, exp_press(c));
      check("release_pulse", release_pulse, exp_release(c));
      check("long_pulse", long_pulse, exp_long(c));
      check("repeat_pulse", repeat_pulse, exp_repeat(c));
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
